// File: rtl/audio_i2s_output_if.sv
// Sample-fetch handshake toward the audio controller plus the I2S pins toward the DAC.
interface audio_i2s_output_if;
  logic        o_busy;
  logic [15:0] i_sample;
  logic        o_i2s_bclk;
  logic        o_i2s_lrck;
  logic        o_i2s_sdata;

  modport master (
    output o_busy, o_i2s_bclk, o_i2s_lrck, o_i2s_sdata,
    input  i_sample
  );

  modport slave (
    input  o_busy, o_i2s_bclk, o_i2s_lrck, o_i2s_sdata,
    output i_sample
  );
endinterface

// File: rtl/audio_i2s_output.sv
// I2S serialiser: divides i_clock into BCLK/LRCK and prefetches the next frame's samples.
// Define AUDIO_I2S_OUTPUT_STEREO_EN for interleaved L,R fetches; default is mono (sample on both channels).
module audio_i2s_output #(
  parameter int BCLK_HALF_PERIOD = 18,
  parameter int FETCH_LATENCY    = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  audio_i2s_output_if.master bus
);

`ifdef AUDIO_I2S_OUTPUT_STEREO_EN
  localparam int FETCHES = 2;
`else
  localparam int FETCHES = 1;
`endif
  localparam int DIV_W = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
  localparam int LAT_W = $clog2(FETCH_LATENCY + 1);

  if (BCLK_HALF_PERIOD < 2) begin : g_bad_div
    $error("BCLK_HALF_PERIOD must be at least 2");
  end
  if (FETCH_LATENCY < 1) begin : g_bad_lat
    $error("FETCH_LATENCY must be at least 1");
  end
  // All fetches of a frame must finish before the next frame load.
  if (64 * BCLK_HALF_PERIOD <= 2 * FETCHES * (FETCH_LATENCY + 2)) begin : g_bad_window
    $error("fetch window does not fit in one I2S frame");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_e;

  logic [DIV_W-1:0] div;
  logic             bclk;
  logic [4:0]       slot;
  logic [31:0]      frame;
  logic [31:0]      nxt_buf;
  logic             sdata;
  logic             div_tc;
  logic             bclk_fall;
  logic             frame_load;

  fetch_state_e     state, state_nxt;
  logic [LAT_W-1:0] wait_cnt;
  logic             busy_c;
  logic             capture;
  logic             last_fetch;

  assign div_tc     = (div == DIV_W'(BCLK_HALF_PERIOD - 1));
  assign bclk_fall  = div_tc & bclk;
  assign frame_load = bclk_fall & (slot == 5'd0);

  // Slot s carries frame bit 31-(s-1); entering slot 1 takes the MSB of the freshly loaded word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div   <= '0;
      bclk  <= 1'b0;
      slot  <= 5'd0;
      frame <= '0;
      sdata <= 1'b0;
    end else begin
      if (div_tc) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 1'b1;
      end
      if (bclk_fall) begin
        slot <= slot + 5'd1;
        if (slot == 5'd0) begin
          frame <= nxt_buf;
          sdata <= nxt_buf[31];
        end else begin
          sdata <= frame[~slot];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ)
        wait_cnt <= LAT_W'(1);
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (frame_load) state_nxt = S_REQ;
      S_REQ: begin
        busy_c    = 1'b0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == LAT_W'(FETCH_LATENCY)) begin
          capture   = 1'b1;
          state_nxt = last_fetch ? S_IDLE : S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef AUDIO_I2S_OUTPUT_STEREO_EN
  logic pair_idx;

  assign last_fetch = pair_idx;

  // First capture of a frame is the left word, second the right.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pair_idx <= 1'b0;
      nxt_buf  <= '0;
    end else if (capture) begin
      pair_idx <= ~pair_idx;
      if (pair_idx)
        nxt_buf[15:0] <= bus.i_sample;
      else
        nxt_buf[31:16] <= bus.i_sample;
    end
  end
`else
  assign last_fetch = 1'b1;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      nxt_buf <= '0;
    else if (capture)
      nxt_buf <= {bus.i_sample, bus.i_sample};
  end
`endif

  assign bus.o_busy      = busy_c;
  assign bus.o_i2s_bclk  = bclk;
  assign bus.o_i2s_lrck  = slot[4];
  assign bus.o_i2s_sdata = sdata;

endmodule
